// File: rtl/fade_pkg.sv
// fade_pkg: shared types and default parameters for the LED colour-wheel fade.
//   sector_t         - hue sector encoding, 0..5 in wheel order
//   DEF_PWM_INTERVAL - default PWM period in clocks (shared with downstream pwm)
//   DEF_STEP         - default ramp increment per tick
//   DEF_TICK_CYCLES  - default clocks per ramp tick (~1 s per sector at 12 MHz)
package fade_pkg;

    typedef enum logic [2:0] {
        SEC_R_G_UP = 3'd0,  // R full, G rising
        SEC_R_DN   = 3'd1,  // R falling, G full
        SEC_B_UP   = 3'd2,  // G full, B rising
        SEC_G_DN   = 3'd3,  // G falling, B full
        SEC_R_UP   = 3'd4,  // R rising, B full
        SEC_B_DN   = 3'd5   // R full, B falling
    } sector_t;

    localparam int unsigned DEF_PWM_INTERVAL = 1200;
    localparam int unsigned DEF_STEP         = 6;
    localparam int unsigned DEF_TICK_CYCLES  = 60000;

endpackage

// File: rtl/tick_prescaler.sv
// tick_prescaler: divides the enabled clock down to one ramp tick per TICK_CYCLES.
//   clk    - clock, rising edge
//   rst    - synchronous active-high reset, clears the count
//   enable - high: count advances; low: count holds
//   tick   - combinational, high in the enabled cycle where the count sits at its last value
module tick_prescaler #(
    parameter int unsigned TICK_CYCLES = 60000
) (
    input  logic clk,
    input  logic rst,
    input  logic enable,
    output logic tick
);

    // Keep at least one bit so TICK_CYCLES = 1 still elaborates.
    localparam int unsigned CW = (TICK_CYCLES > 1) ? $clog2(TICK_CYCLES) : 1;
    localparam logic [CW-1:0] LAST = CW'(TICK_CYCLES - 1);

    logic [CW-1:0] count_q, count_d;

    always_comb begin
        tick    = enable && (count_q == LAST);
        count_d = count_q;
        if (enable) begin
            count_d = tick ? '0 : count_q + 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            count_q <= '0;
        end else begin
            count_q <= count_d;
        end
    end

endmodule

// File: rtl/hsv_fade.sv
// hsv_fade: colour-wheel sequencer producing the three pwm duty words.
// Hue walks through six sectors; in each one channel ramps linearly while the
// other two sit at full or zero.
//   clk              - clock, rising edge
//   rst              - synchronous active-high reset
//   enable           - high: sequencer runs; low: all state frozen
//   red/green/blue   - registered duty words (0..PWM_INTERVAL-1)
//   sector           - registered current hue sector, 0..5
module hsv_fade
    import fade_pkg::*;
#(
    parameter int unsigned PWM_INTERVAL = DEF_PWM_INTERVAL,
    parameter int unsigned STEP         = DEF_STEP,
    parameter int unsigned TICK_CYCLES  = DEF_TICK_CYCLES,
    localparam int unsigned W           = $clog2(PWM_INTERVAL)
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         enable,
    output logic [W-1:0] red,
    output logic [W-1:0] green,
    output logic [W-1:0] blue,
    output logic [2:0]   sector
);

    localparam logic [W-1:0] MAX      = W'(PWM_INTERVAL - 1);
    localparam logic [W:0]   STEP_EXT = (W+1)'(STEP);

    logic         tick;
    logic [W-1:0] level_q, level_d;
    sector_t      sector_q, sector_d;
    logic [W:0]   level_sum;
    logic [W-1:0] rise, fall;
    logic [W-1:0] red_q, red_d, green_q, green_d, blue_q, blue_d;

    tick_prescaler #(
        .TICK_CYCLES(TICK_CYCLES)
    ) u_prescaler (
        .clk   (clk),
        .rst   (rst),
        .enable(enable),
        .tick  (tick)
    );

    // Ramp and sector advance. The sum carries an extra bit so a large STEP
    // clamps to MAX instead of wrapping.
    always_comb begin
        level_d   = level_q;
        sector_d  = sector_q;
        level_sum = {1'b0, level_q} + STEP_EXT;
        if (tick) begin
            if (level_q != MAX) begin
                level_d = (level_sum > {1'b0, MAX}) ? MAX : level_sum[W-1:0];
            end else begin
                level_d  = '0;
                sector_d = (sector_q == SEC_B_DN) ? SEC_R_G_UP : sector_t'(sector_q + 3'd1);
            end
        end
    end

    // Decode from next-state so outputs move on the same edge as the state.
    always_comb begin
        rise    = level_d;
        fall    = MAX - level_d;
        red_d   = '0;
        green_d = '0;
        blue_d  = '0;
        unique case (sector_d)
            SEC_R_G_UP: begin red_d = MAX;  green_d = rise; blue_d = '0;   end
            SEC_R_DN:   begin red_d = fall; green_d = MAX;  blue_d = '0;   end
            SEC_B_UP:   begin red_d = '0;   green_d = MAX;  blue_d = rise; end
            SEC_G_DN:   begin red_d = '0;   green_d = fall; blue_d = MAX;  end
            SEC_R_UP:   begin red_d = rise; green_d = '0;   blue_d = MAX;  end
            SEC_B_DN:   begin red_d = MAX;  green_d = '0;   blue_d = fall; end
            default:    begin red_d = '0;   green_d = '0;   blue_d = '0;   end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            level_q  <= '0;
            sector_q <= SEC_R_G_UP;
            red_q    <= MAX;
            green_q  <= '0;
            blue_q   <= '0;
        end else begin
            level_q  <= level_d;
            sector_q <= sector_d;
            red_q    <= red_d;
            green_q  <= green_d;
            blue_q   <= blue_d;
        end
    end

    assign red    = red_q;
    assign green  = green_q;
    assign blue   = blue_q;
    assign sector = sector_q;

endmodule

// File: tb/tb_hsv_fade.sv
// tb_hsv_fade: scoreboard bench for hsv_fade. Two instances share clk/rst/enable:
//   A: PWM_INTERVAL=12, STEP=4,  TICK_CYCLES=3
//   B: PWM_INTERVAL=12, STEP=11, TICK_CYCLES=1
// A reference model predicts every cycle's outputs into a queue; a negedge
// monitor pops and compares against the DUT outputs.
module tb_hsv_fade;

    localparam int MX = 11;

    typedef struct {
        int p;
        int l;
        int s;
    } st_t;

    logic       clk;
    logic       rst;
    logic       enable;
    logic [3:0] a_red, a_green, a_blue;
    logic [2:0] a_sector;
    logic [3:0] b_red, b_green, b_blue;
    logic [2:0] b_sector;

    int checks   = 0;
    int failures = 0;

    logic [31:0] q_a[$];
    logic [31:0] q_b[$];
    st_t         m_a = '{0, 0, 0};
    st_t         m_b = '{0, 0, 0};
    bit          started = 0;

    hsv_fade #(
        .PWM_INTERVAL(12),
        .STEP        (4),
        .TICK_CYCLES (3)
    ) u_dut_a (
        .clk   (clk),
        .rst   (rst),
        .enable(enable),
        .red   (a_red),
        .green (a_green),
        .blue  (a_blue),
        .sector(a_sector)
    );

    hsv_fade #(
        .PWM_INTERVAL(12),
        .STEP        (11),
        .TICK_CYCLES (1)
    ) u_dut_b (
        .clk   (clk),
        .rst   (rst),
        .enable(enable),
        .red   (b_red),
        .green (b_green),
        .blue  (b_blue),
        .sector(b_sector)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Model: hue wheel as plain integer arithmetic.
    function automatic st_t next_st(st_t c, int tc, int stp, bit r, bit en);
        st_t n = c;
        if (r) begin
            n = '{0, 0, 0};
        end else if (en) begin
            if (c.p == tc - 1) begin
                n.p = 0;
                if (c.l != MX) begin
                    n.l = (c.l + stp > MX) ? MX : c.l + stp;
                end else begin
                    n.l = 0;
                    n.s = (c.s + 1) % 6;
                end
            end else begin
                n.p = c.p + 1;
            end
        end
        return n;
    endfunction

    function automatic logic [31:0] colours(st_t c);
        int r, g, b;
        int up = c.l;
        int dn = MX - c.l;
        case (c.s)
            0: begin r = MX; g = up; b = 0;  end
            1: begin r = dn; g = MX; b = 0;  end
            2: begin r = 0;  g = MX; b = up; end
            3: begin r = 0;  g = dn; b = MX; end
            4: begin r = up; g = 0;  b = MX; end
            default: begin r = MX; g = 0; b = dn; end
        endcase
        return {8'(c.s), 8'(r), 8'(g), 8'(b)};
    endfunction

    always @(posedge clk) begin
        m_a = next_st(m_a, 3, 4, rst, enable);
        m_b = next_st(m_b, 1, 11, rst, enable);
        q_a.push_back(colours(m_a));
        q_b.push_back(colours(m_b));
        started = 1;
    end

    always @(negedge clk) begin
        if (started) begin
            if (q_a.size() == 0) begin
                chk("scoreboard_a_empty", 32'd1, 32'd0);
            end else begin
                chk("dut_a_outputs", {8'(a_sector), 8'(a_red), 8'(a_green), 8'(a_blue)},
                    q_a.pop_front());
            end
            if (q_b.size() == 0) begin
                chk("scoreboard_b_empty", 32'd1, 32'd0);
            end else begin
                chk("dut_b_outputs", {8'(b_sector), 8'(b_red), 8'(b_green), 8'(b_blue)},
                    q_b.pop_front());
            end
        end
    end

    task automatic cycles(input int n);
        for (int i = 0; i < n; i++) begin
            @(posedge clk);
            #1;
        end
    endtask

    function automatic logic [31:0] pack_a();
        return {8'(a_sector), 8'(a_red), 8'(a_green), 8'(a_blue)};
    endfunction

    initial begin
        int guard;
        rst    = 1'b1;
        enable = 1'b1;
        cycles(2);
        chk("reset_values", pack_a(), {8'd0, 8'd11, 8'd0, 8'd0});
        rst = 1'b0;
        cycles(2);
        chk("hold_after_release", pack_a(), {8'd0, 8'd11, 8'd0, 8'd0});
        cycles(1);
        chk("tick1_green4", pack_a(), {8'd0, 8'd11, 8'd4, 8'd0});
        cycles(6);
        chk("tick3_green_clamped", pack_a(), {8'd0, 8'd11, 8'd11, 8'd0});
        cycles(3);
        chk("tick4_sector1", pack_a(), {8'd1, 8'd11, 8'd11, 8'd0});
        cycles(3);
        chk("tick5_red7", pack_a(), {8'd1, 8'd7, 8'd11, 8'd0});

        // Rest of the wheel: 24 ticks from reset lands back on sector 0.
        cycles(72 - 15);
        chk("full_wheel", pack_a(), {8'd0, 8'd11, 8'd0, 8'd0});

        // Pause mid-prescale: one cycle into the count, then freeze.
        cycles(7);
        enable = 1'b0;
        cycles(10);
        enable = 1'b1;
        cycles(20);

        // Mid-op reset while A sits in sector 3.
        guard = 0;
        while (a_sector != 3'd3 && guard < 200) begin
            cycles(1);
            guard++;
        end
        chk("reach_sector3", 32'(a_sector), 32'd3);
        rst = 1'b1;
        cycles(1);
        chk("midop_reset", pack_a(), {8'd0, 8'd11, 8'd0, 8'd0});
        rst = 1'b0;
        cycles(2);
        chk("midop_no_early_tick", pack_a(), {8'd0, 8'd11, 8'd0, 8'd0});
        cycles(1);
        chk("midop_tick_after3", pack_a(), {8'd0, 8'd11, 8'd4, 8'd0});

        // Randomized enable/reset traffic.
        for (int i = 0; i < 3000; i++) begin
            enable = ($urandom_range(0, 3) != 0);
            rst    = ($urandom_range(0, 149) == 0);
            cycles(1);
        end

        rst    = 1'b0;
        enable = 1'b1;
        cycles(2);
        $display("End of test - %0d assertions evaluated, %0d failures", checks, failures);
        $finish;
    end

endmodule
